// File: rtl/tile_feeder.sv
// rtl/tile_feeder.sv - DIMxDIM tile buffer that streams vectors into the systolic delay lines
//
// Loads a tile one row per in_valid/in_ready handshake, then on start streams
// DIM data beats followed by FLUSH zero beats with shift_en held high, so the
// deepest downstream delay line drains before the next tile arrives.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_row holds a valid row
//   in_ready   feeder accepts a row this cycle (registered, state only)
//   in_row     row data, element j at [j*BITS +: BITS]
//   start      single-cycle request to stream the loaded tile
//   shift_en   shift enable for the downstream delay lines
//   lane_data  beat vector, lane i at [i*BITS +: BITS]
//   busy       high while streaming or flushing
//   done       one-cycle pulse when the machine returns to LOAD
//
// Build option: TILE_FEEDER_TRANSPOSE_EN streams columns (beat k, lane i = A[i][k])
// instead of rows (beat k, lane i = A[k][i]).

module tile_feeder #(
  parameter int DIM   = 8,
  parameter int BITS  = 8,
  parameter int FLUSH = 2*DIM-1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIM*BITS-1:0] in_row,
  input  logic                start,
  output logic                shift_en,
  output logic [DIM*BITS-1:0] lane_data,
  output logic                busy,
  output logic                done
);

  localparam int RW   = $clog2(DIM+1);
  localparam int IW   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CMAX = (FLUSH > DIM) ? FLUSH : DIM;
  localparam int BW   = $clog2(CMAX+1);

  typedef enum logic [1:0] {S_LOAD, S_FULL, S_STREAM, S_FLUSH} state_t;

  state_t              state, nstate;
  logic [RW-1:0]       rcnt;
  logic [BW-1:0]       bcnt, nbcnt;
  logic [BITS-1:0]     mem [DIM][DIM];
  logic                accept;
  logic                in_ready_d, shift_en_d, busy_d, done_d;
  logic [DIM*BITS-1:0] lane_d;
  logic [IW-1:0]       beat_idx;

  // in_ready is only ever high in LOAD, so accept needs no state qualifier.
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_LOAD:   if (accept && rcnt == RW'(DIM-1)) nstate = S_FULL;
      S_FULL:   if (start) nstate = S_STREAM;
      S_STREAM: if (bcnt == BW'(DIM-1)) nstate = (FLUSH == 0) ? S_LOAD : S_FLUSH;
      S_FLUSH:  if (bcnt == BW'(FLUSH-1)) nstate = S_LOAD;
      default:  nstate = S_LOAD;
    endcase
  end

  // All outputs are registered from the next state, so they line up with the
  // state register: the first beat appears the cycle after start is sampled.
  always_comb begin
    nbcnt = '0;
    if ((nstate == state) && (state == S_STREAM || state == S_FLUSH))
      nbcnt = bcnt + BW'(1);
    beat_idx   = nbcnt[IW-1:0];
    in_ready_d = (nstate == S_LOAD);
    shift_en_d = (nstate == S_STREAM) || (nstate == S_FLUSH);
    busy_d     = shift_en_d;
    done_d     = (nstate == S_LOAD) && (state == S_STREAM || state == S_FLUSH);
    lane_d     = '0;
    if (nstate == S_STREAM) begin
      for (int i = 0; i < DIM; i++) begin
`ifdef TILE_FEEDER_TRANSPOSE_EN
        lane_d[i*BITS +: BITS] = mem[i][beat_idx];
`else
        lane_d[i*BITS +: BITS] = mem[beat_idx][i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lane_data <= '0;
      bcnt      <= '0;
    end else begin
      in_ready  <= in_ready_d;
      shift_en  <= shift_en_d;
      busy      <= busy_d;
      done      <= done_d;
      lane_data <= lane_d;
      bcnt      <= nbcnt;
    end
  end

  // Row counter is cleared when streaming begins, so it is already zero when
  // LOAD is re-entered and a row can be taken in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rcnt <= '0;
    else if (accept)                  rcnt <= rcnt + RW'(1);
    else if (state == S_FULL && start) rcnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          mem[r][c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < DIM; c++)
        mem[rcnt[IW-1:0]][c] <= in_row[c*BITS +: BITS];
    end
  end

endmodule
